// File: rtl/layer_blend.sv
// layer_blend: streams NUM_BLOCKS block pairs from layers A and B, blends every byte lane
// with the mode/alpha latched at start, and writes the result block to the output buffer.
module layer_blend #(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int ALPHA_BITS      = 8,
    parameter int NUM_BLOCKS      = 1024,
    parameter int SRC_A_BASE      = 0,
    parameter int SRC_B_BASE      = 65536,
    parameter int DST_BASE        = 143360,
    localparam int W = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      blend_en,
    input  logic                      abort,
    input  logic [1:0]                blend_mode,
    input  logic [ALPHA_BITS-1:0]     alpha_value,
    output logic                      busy,
    output logic                      blend_done,
    output logic                      read_enable,
    output logic                      write_enable,
    output logic [ADDR_SIZE_BITS-1:0] address,
    input  logic [W-1:0]              read_data,
    output logic [W-1:0]              write_data
);
    localparam int LANES = W / 8;
    localparam int IW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1;
    localparam int SW = 9 + ALPHA_BITS;
    localparam logic [ALPHA_BITS:0] FULL = {1'b1, {ALPHA_BITS{1'b0}}};

    typedef enum logic [3:0] {IDLE, RD_A, LAT_A, RD_B, LAT_B, BLEND, WRITE, NEXT, DONE} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0] a_q, b_q, wd_q, blend_d;
    logic [1:0] mode_q;
    logic [ALPHA_BITS-1:0] alpha_q;
    logic [ADDR_SIZE_BITS-1:0] off;
    logic last;

    function automatic logic [7:0] blend_byte(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] m, input logic [ALPHA_BITS-1:0] al);
        logic [ALPHA_BITS:0] w;
        logic [SW-1:0] s;
        logic [8:0] add;
        logic [15:0] mul;
        // all-ones alpha means "fully A" so the weight saturates to 2^ALPHA_BITS
        w = &al ? FULL : {1'b0, al};
        s = SW'(a) * SW'(w) + SW'(b) * SW'(FULL - w);
        add = {1'b0, a} + {1'b0, b};
        mul = {8'b0, a} * {8'b0, b} + 16'd255;
        return m == 2'd0 ? 8'(s >> ALPHA_BITS) :
               m == 2'd1 ? (add > 9'd255 ? 8'hFF : add[7:0]) :
               m == 2'd2 ? 8'(mul >> 8) : a;
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign blend_d[l*8 +: 8] = blend_byte(a_q[l*8 +: 8], b_q[l*8 +: 8], mode_q, alpha_q);
    end

    assign last = idx_q == IW'(NUM_BLOCKS - 1);
    assign off = ADDR_SIZE_BITS'(idx_q) * ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
    assign write_data = wd_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            mode_q  <= '0;
            alpha_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && blend_en) begin
                mode_q  <= blend_mode;
                alpha_q <= alpha_value;
            end
            if (state_q == LAT_A) a_q <= read_data;
            if (state_q == LAT_B) b_q <= read_data;
            if (state_q == BLEND) wd_q <= blend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: if (blend_en) begin
                state_d = RD_A;
                idx_d = '0;
            end
            RD_A:  state_d = LAT_A;
            LAT_A: state_d = RD_B;
            RD_B:  state_d = LAT_B;
            LAT_B: state_d = BLEND;
            BLEND: state_d = WRITE;
            WRITE: state_d = NEXT;
            NEXT: begin
                state_d = last ? DONE : RD_A;
                idx_d = last ? idx_q : idx_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_comb begin
        busy         = state_q != IDLE;
        blend_done   = state_q == DONE;
        read_enable  = state_q == RD_A || state_q == RD_B;
        write_enable = state_q == WRITE;
        address      = state_q == RD_A  ? ADDR_SIZE_BITS'(SRC_A_BASE) + off :
                       state_q == RD_B  ? ADDR_SIZE_BITS'(SRC_B_BASE) + off :
                       state_q == WRITE ? ADDR_SIZE_BITS'(DST_BASE) + off : '0;
    end
endmodule

// File: tb/tb_layer_blend.sv
// tb_layer_blend: random and directed frames checked against a per-byte arithmetic model.
module tb_layer_blend;
    localparam int AW = 24, WB = 3, DW = 4, AB = 8, NB = 2;
    localparam int SRC_A = 0, SRC_B = 65536, DST = 143360;
    localparam int W = WB * DW * 8, LANES = W / 8;

    logic clk = 0, n_rst = 1, blend_en = 0, abort = 0;
    logic [1:0] blend_mode = 0;
    logic [AB-1:0] alpha_value = 0;
    logic busy, blend_done, read_enable, write_enable;
    logic [AW-1:0] address;
    logic [W-1:0] read_data = '0, write_data;

    logic [W-1:0] blk_a [NB];
    logic [W-1:0] blk_b [NB];
    logic [AW-1:0] wa [$];
    logic [W-1:0] wd [$];
    int done_cnt = 0, both_cnt = 0;
    int total = 0, bad = 0;

    layer_blend #(.ADDR_SIZE_BITS(AW), .WORD_SIZE_BYTES(WB), .DATA_SIZE_WORDS(DW),
                  .ALPHA_BITS(AB), .NUM_BLOCKS(NB), .SRC_A_BASE(SRC_A),
                  .SRC_B_BASE(SRC_B), .DST_BASE(DST)) dut (
        .clk(clk), .n_rst(n_rst), .blend_en(blend_en), .abort(abort),
        .blend_mode(blend_mode), .alpha_value(alpha_value), .busy(busy),
        .blend_done(blend_done), .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .read_data(read_data), .write_data(write_data));

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lookup(input logic [AW-1:0] a);
        for (int k = 0; k < NB; k++) begin
            if (int'(a) == SRC_A + k * DW) return blk_a[k];
            if (int'(a) == SRC_B + k * DW) return blk_b[k];
        end
        return '0;
    endfunction

    always @(posedge clk) if (read_enable) read_data <= lookup(address);

    always @(negedge clk) begin
        if (write_enable) begin
            wa.push_back(address);
            wd.push_back(write_data);
        end
        if (blend_done) done_cnt++;
        if (read_enable && write_enable) both_cnt++;
    end

    function automatic int model(input int a, input int b, input int m, input int al);
        int w;
        w = (al == (1 << AB) - 1) ? (1 << AB) : al;
        case (m)
            0: return (a * w + b * ((1 << AB) - w)) / (1 << AB);
            1: return (a + b > 255) ? 255 : a + b;
            2: return (a * b + 255) / 256;
            default: return a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] av, input logic [7:0] bv);
        for (int k = 0; k < NB; k++) begin
            blk_a[k] = {LANES{av}};
            blk_b[k] = {LANES{bv}};
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NB; k++)
            for (int l = 0; l < LANES; l++) begin
                blk_a[k][l*8 +: 8] = 8'($urandom);
                blk_b[k][l*8 +: 8] = 8'($urandom);
            end
    endtask

    task automatic start(input logic [1:0] m, input logic [7:0] al);
        @(negedge clk);
        blend_mode = m;
        alpha_value = al;
        blend_en = 1;
        @(posedge clk);
        #1 blend_en = 0;
    endtask

    task automatic run_frame(input logic [1:0] m, input logic [7:0] al, input string tag);
        int n, wbase, dbase;
        logic got;
        logic [W-1:0] e;
        wbase = wa.size();
        dbase = done_cnt;
        start(m, al);
        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                blend_en = 1;
                blend_mode = ~m;
                alpha_value = ~al;
            end
            if (n == 6) blend_en = 0;
            if (blend_done) got = 1;
        end
        check({tag, "_latency"}, 128'(n), 128'(7 * NB + 1));
        @(negedge clk);
        check({tag, "_idle"}, 128'(busy), 128'(0));
        check({tag, "_done_cnt"}, 128'(done_cnt - dbase), 128'(1));
        check({tag, "_writes"}, 128'(wa.size() - wbase), 128'(NB));
        for (int k = 0; k < NB; k++) begin
            for (int l = 0; l < LANES; l++)
                e[l*8 +: 8] = 8'(model(int'(blk_a[k][l*8 +: 8]), int'(blk_b[k][l*8 +: 8]), int'(m), int'(al)));
            if (wa.size() > wbase + k) begin
                check({tag, "_addr"}, 128'(wa[wbase + k]), 128'(DST + k * DW));
                check({tag, "_data"}, 128'(wd[wbase + k]), 128'(e));
            end
        end
    endtask

    initial begin
        int wbase, dbase;
        #2 n_rst = 0;
        #1;
        check("rst_outputs", 128'({busy, blend_done, read_enable, write_enable}), 128'(0));
        check("rst_address", 128'(address), 128'(0));
        check("rst_wdata", 128'(write_data), 128'(0));
        repeat (2) @(negedge clk);
        n_rst = 1;
        @(negedge clk);
        check("idle_after_rst", 128'(busy), 128'(0));

        fill(8'd200, 8'd100);
        run_frame(2'd0, 8'h80, "alpha_half");
        fill(8'd37, 8'd250);
        run_frame(2'd0, 8'hFF, "alpha_ff");
        run_frame(2'd0, 8'h00, "alpha_00");
        fill(8'd200, 8'd100);
        run_frame(2'd1, 8'h00, "add_sat");
        fill(8'd255, 8'd255);
        run_frame(2'd2, 8'h00, "mul_max");
        fill(8'd0, 8'd173);
        run_frame(2'd2, 8'h00, "mul_zero");
        fill(8'd9, 8'd77);
        run_frame(2'd3, 8'h00, "copy_a");
        for (int i = 0; i < 6; i++) begin
            fill_rand();
            run_frame(2'(i % 4), 8'($urandom), "random");
        end

        // abort while block 0 is in BLEND
        fill_rand();
        wbase = wa.size();
        dbase = done_cnt;
        start(2'd0, 8'h80);
        repeat (5) @(negedge clk);
        check("abort_pre_busy", 128'(busy), 128'(1));
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_busy", 128'(busy), 128'(0));
        repeat (10) @(negedge clk);
        check("abort_writes", 128'(wa.size() - wbase), 128'(0));
        check("abort_done", 128'(done_cnt - dbase), 128'(0));
        run_frame(2'd1, 8'h00, "after_abort");

        // reset dropped during WRITE of block 0
        fill_rand();
        start(2'd2, 8'h00);
        repeat (6) @(negedge clk);
        check("pre_rst_we", 128'(write_enable), 128'(1));
        #2 n_rst = 0;
        #1;
        check("midrst_outputs", 128'({busy, blend_done, read_enable, write_enable}), 128'(0));
        check("midrst_address", 128'(address), 128'(0));
        check("midrst_wdata", 128'(write_data), 128'(0));
        @(negedge clk);
        n_rst = 1;
        repeat (5) @(negedge clk);
        check("rst_needs_start", 128'(busy), 128'(0));
        fill_rand();
        run_frame(2'd0, 8'($urandom), "after_rst");

        check("no_rw_overlap", 128'(both_cnt), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_blend.md
LAYER_BLEND -- requirements
Module: layer_blend

Interface
REQ-001 SHALL have parameter ADDR_SIZE_BITS, default 24, memory address width.
REQ-002 SHALL have parameter WORD_SIZE_BYTES, default 3, bytes per pixel word.
REQ-003 SHALL have parameter DATA_SIZE_WORDS, default 64, words per memory block.
REQ-004 SHALL have parameter ALPHA_BITS, default 8, alpha weight width.
REQ-005 SHALL have parameter NUM_BLOCKS, default 1024, blocks per frame (>=1).
REQ-006 SHALL have parameters SRC_A_BASE, SRC_B_BASE and DST_BASE, defaults 0, 65536 and 143360, which are the word base addresses of layer A, layer B and the output buffer.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-008 SHALL have port n_rst, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port blend_en, input, 1 bit, start request.
REQ-010 SHALL have port abort, input, 1 bit, synchronous cancel.
REQ-011 SHALL have port blend_mode, input, 2 bits: 0 ALPHA, 1 ADD, 2 MULTIPLY, 3 COPY_A.
REQ-012 SHALL have port alpha_value, input, ALPHA_BITS bits, layer-A weight.
REQ-013 SHALL have port busy, output, 1 bit, high outside IDLE.
REQ-014 SHALL have port blend_done, output, 1 bit, one-cycle completion pulse.
REQ-015 SHALL have ports read_enable and write_enable, outputs, 1 bit each, memory strobes.
REQ-016 SHALL have port address, output, ADDR_SIZE_BITS bits, memory address.
REQ-017 SHALL have port read_data, input, W = WORD_SIZE_BYTES*DATA_SIZE_WORDS*8 bits.
REQ-018 SHALL have port write_data, output, W bits.

Function
REQ-019 SHALL implement states IDLE, RD_A, LAT_A, RD_B, LAT_B, BLEND, WRITE, NEXT and DONE.
REQ-020 SHALL, in IDLE with blend_en=1, latch blend_mode and alpha_value, clear the block index to 0, and move to RD_A; while busy, blend_en SHALL be ignored.
REQ-021 SHALL, in RD_A, drive read_enable=1 with address=SRC_A_BASE+idx*DATA_SIZE_WORDS.
REQ-022 SHALL, in LAT_A, capture read_data into register A; memory read latency is fixed at 1 cycle.
REQ-023 SHALL, in RD_B and LAT_B, do the same for SRC_B_BASE into register B.
REQ-024 SHALL, in BLEND, compute all W/8 byte lanes in parallel and register the result into write_data.
REQ-025 SHALL, in WRITE, drive write_enable=1 with address=DST_BASE+idx*DATA_SIZE_WORDS for exactly 1 cycle.
REQ-026 SHALL, in NEXT, go to DONE if idx==NUM_BLOCKS-1, else increment idx and go to RD_A; each block therefore takes 7 cycles.
REQ-027 SHALL, in DONE, pulse blend_done=1 for 1 cycle, then go to IDLE.
REQ-028 SHALL, in ALPHA mode, use weight w = 2^ALPHA_BITS when alpha_value is all-ones, else w = alpha_value, and compute out=(a*w + b*(2^ALPHA_BITS-w))>>ALPHA_BITS, truncated, with internal width 8+ALPHA_BITS+1.
REQ-029 SHALL, in ADD mode, compute out=min(a+b,255).
REQ-030 SHALL, in MULTIPLY mode, compute out=(a*b+255)>>8.
REQ-031 SHALL, in COPY_A mode, compute out=a.
REQ-032 SHALL, when abort=1 in any state other than IDLE, go to IDLE next cycle with no further strobes and no blend_done; abort in IDLE SHALL have no effect; abort SHALL take priority over every other transition.
REQ-033 SHALL, whenever the state is not RD_A, RD_B or WRITE, hold read_enable and write_enable at 0 and address at 0.
REQ-034 SHALL never assert read_enable and write_enable in the same cycle.
REQ-035 SHALL use the latched mode and alpha for the whole frame; input changes mid-frame SHALL have no effect.

Reset
REQ-036 SHALL, while n_rst=0, immediately force state=IDLE, idx=0, registers A and B=0, write_data=0, busy=0, blend_done=0, read_enable=0, write_enable=0 and address=0, including when reset is asserted mid-frame.
REQ-037 SHALL, after reset release, require a new blend_en to start.

Verification
REQ-038 SHALL verify, with NUM_BLOCKS=2, DATA_SIZE_WORDS=4, ALPHA mode, alpha=0x80, all A bytes=200 and all B bytes=100: both blocks write bytes=150 to DST_BASE and DST_BASE+4, and blend_done pulses once, 15 cycles after the start.
REQ-039 SHALL verify alpha edges: alpha=0xFF with A=37 and B=250 gives out=37; alpha=0x00 gives out=250.
REQ-040 SHALL verify ADD with 200+100 gives 255, MULTIPLY with 255*255 gives 255, MULTIPLY with 0*x gives 0, and COPY_A with A=9 gives 9.
REQ-041 SHALL verify that abort asserted in BLEND of block 0 gives no write_enable, no blend_done, and busy=0 next cycle, and that a following blend_en restarts at idx 0.
REQ-042 SHALL verify that n_rst dropped during WRITE clears all outputs asynchronously, and that a blend_en asserted mid-frame is ignored, with exactly NUM_BLOCKS writes per frame.
